// File: rtl/pf_pkg.sv
// Shared types and helpers for the streaming peak finder: FSM states, record
// widths, the sentinel index and the IEEE-754 ordering key.
package pf_pkg;

    localparam int PF_DATA_W = 32;
    localparam int PF_IDX_W  = 13;
    localparam int PF_REC_W  = PF_IDX_W + PF_DATA_W + 1;

    // Index field of the record emitted when a frame produced no accepted hits
    localparam logic [PF_IDX_W-1:0] SENTINEL_IDX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } pf_state_e;

    // Maps an IEEE-754 single to an unsigned key whose integer order is the
    // float order (with -0 < +0); NaNs simply land at the extremes.
    function automatic logic [31:0] fp_key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        return fp_key(a) > fp_key(b);
    endfunction

    function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
        return fp_key(a) < fp_key(b);
    endfunction

endpackage

// File: rtl/pf_record_fifo.sv
// Small synchronous FIFO for output records; push and pop may coincide.
module pf_record_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 46
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/peak_finder_stream.sv
// Streaming local-extremum detector: tests each sample in place against its
// neighbours, a threshold and periodic index windows, and emits {index, value}.
module peak_finder_stream
    import pf_pkg::*;
#(
    parameter int DATA_W     = PF_DATA_W,
    parameter int IDX_W      = PF_IDX_W,
    parameter int FRAME_LEN  = 8192,
    parameter int WIN_START  = 899,
    parameter int WIN_LEN    = 6,
    parameter int WIN_STRIDE = 53,
    parameter int MAX_PEAKS  = 35,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic [DATA_W-1:0]       threshold,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_W-1:0]       s_axis_tdata,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [IDX_W+DATA_W-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        peak_count,
    output logic                    overflow
);
    localparam int REC_W = IDX_W + DATA_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] WIN_START_I = IDX_W'(WIN_START);
    localparam logic [IDX_W-1:0] WIN_LEN_I   = IDX_W'(WIN_LEN);
    localparam logic [IDX_W-1:0] STRIDE_LAST = IDX_W'(WIN_STRIDE - 1);
    localparam logic [IDX_W-1:0] MAX_PEAKS_I = IDX_W'(MAX_PEAKS);

    pf_state_e state, state_nx;

    logic              mode_q;
    logic [DATA_W-1:0] thr_q;
    logic [DATA_W-1:0] prev_q, curr_q;
    logic [IDX_W-1:0]  idx_q;          // index of the next sample to be accepted
    logic              win_on_q;       // candidate (idx_q-1) has reached WIN_START
    logic [IDX_W-1:0]  phase_q;        // (candidate - WIN_START) mod WIN_STRIDE
    logic              hold_valid_q;
    logic [IDX_W-1:0]  hold_idx_q;
    logic [DATA_W-1:0] hold_val_q;
    logic              final_pushed_q;
    logic [IDX_W-1:0]  peak_count_q;
    logic              overflow_q;

    logic              s_fire, m_fire, frame_end;
    logic              cand_ok, extreme, hit, keep, flush_push;
    logic              fifo_push, fifo_full, fifo_empty;
    logic [REC_W-1:0]  fifo_din, fifo_dout;

    assign s_axis_tready = (state == ST_RUN) && !fifo_full;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_axis_tvalid && m_axis_tready;
    assign frame_end     = s_fire && (s_axis_tlast || idx_q == LAST_IDX);

    // The incoming sample is the right-hand neighbour of candidate idx_q-1.
    assign cand_ok = (idx_q >= IDX_W'(2)) && win_on_q && (phase_q < WIN_LEN_I);
    assign extreme = mode_q
        ? (fp_lt(curr_q, prev_q) && fp_lt(curr_q, s_axis_tdata) && fp_lt(curr_q, thr_q))
        : (fp_gt(curr_q, prev_q) && fp_gt(curr_q, s_axis_tdata) && fp_gt(curr_q, thr_q));
    assign hit        = s_fire && cand_ok && extreme;
    assign keep       = hit && (peak_count_q < MAX_PEAKS_I);
    assign flush_push = (state == ST_FLUSH) && !final_pushed_q && !fifo_full;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        fifo_push = 1'b0;
        fifo_din  = '0;
        if (flush_push) begin
            fifo_push = 1'b1;
            fifo_din  = hold_valid_q ? {hold_idx_q, hold_val_q, 1'b1}
                                     : {IDX_W'(SENTINEL_IDX), {DATA_W{1'b0}}, 1'b1};
        end else if (keep && hold_valid_q) begin
            fifo_push = 1'b1;
            fifo_din  = {hold_idx_q, hold_val_q, 1'b0};
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (frame_end) state_nx = ST_FLUSH;
            ST_FLUSH: if (m_fire && m_axis_tlast) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            mode_q         <= 1'b0;
            thr_q          <= '0;
            prev_q         <= '0;
            curr_q         <= '0;
            idx_q          <= '0;
            win_on_q       <= 1'b0;
            phase_q        <= '0;
            hold_valid_q   <= 1'b0;
            hold_idx_q     <= '0;
            hold_val_q     <= '0;
            final_pushed_q <= 1'b0;
            peak_count_q   <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == ST_IDLE && start) begin
                mode_q         <= mode;
                thr_q          <= threshold;
                idx_q          <= '0;
                win_on_q       <= 1'b0;
                phase_q        <= '0;
                hold_valid_q   <= 1'b0;
                final_pushed_q <= 1'b0;
                peak_count_q   <= '0;
                overflow_q     <= 1'b0;
            end

            if (s_fire) begin
                prev_q   <= curr_q;
                curr_q   <= s_axis_tdata;
                idx_q    <= idx_q + IDX_W'(1);
                // The sample just accepted becomes the next candidate.
                win_on_q <= win_on_q || (idx_q == WIN_START_I);
                if (idx_q == WIN_START_I)
                    phase_q <= '0;
                else if (win_on_q)
                    phase_q <= (phase_q == STRIDE_LAST) ? '0 : phase_q + IDX_W'(1);
            end

            if (hit && peak_count_q != '1) peak_count_q <= peak_count_q + IDX_W'(1);
            if (hit && !keep)              overflow_q   <= 1'b1;

            if (keep) begin
                hold_valid_q <= 1'b1;
                hold_idx_q   <= idx_q - IDX_W'(1);
                hold_val_q   <= curr_q;
            end

            if (flush_push) final_pushed_q <= 1'b1;
        end
    end

    pf_record_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (m_fire),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout[REC_W-1:1];
    assign m_axis_tlast  = !fifo_empty && fifo_dout[0];
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
    assign peak_count    = peak_count_q;
    assign overflow      = overflow_q;

endmodule
